boot_load_sequencer: RTL and testbench

Top-level sequencer for UART program loading. It holds the UART instruction loader in reset, then runs it, and owns the program memory write/read port while loading. It holds the CPU in reset until the program is complete and then hands the memory port to CPU instruction fetch. It also watches for a stalled UART stream (timeout) and supports a reload request that restarts the whole load sequence.

---
 rtl/boot_load_sequencer.sv | 149 ++++++++++++++
 tb/tb_boot_load_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_load_sequencer.sv
// Boot load sequencer: holds the UART loader in reset, runs the program load, settles,
// then releases the CPU and hands it the program memory port. Watches for stalled loads.
module boot_load_sequencer #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 10,
   parameter int LDR_RST_CYCLES = 4,
   parameter int SETTLE_CYCLES  = 2,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic                  reload_req,
   input  logic                  byte_strobe,
   input  logic                  ldr_inst_rdy,
   input  logic [ADDR_WIDTH-1:0] ldr_wr_addr,
   input  logic [DATA_WIDTH-1:0] ldr_wr_data,
   input  logic                  ldr_prog_rdy,
   input  logic [ADDR_WIDTH-1:0] cpu_fetch_addr,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  ldr_rst_n,
   output logic                  cpu_rst_n,
   output logic                  timeout_err,
   output logic [ADDR_WIDTH-1:0] inst_count,
   output logic [2:0]            boot_state
);

   typedef enum logic [2:0] {
      LDR_RESET = 3'b000,
      LOAD      = 3'b001,
      SETTLE    = 3'b010,
      RUN       = 3'b011,
      ERROR     = 3'b100
   } state_e;

   localparam int CNT_MAX = (LDR_RST_CYCLES > SETTLE_CYCLES) ? LDR_RST_CYCLES : SETTLE_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int IW      = $clog2(TIMEOUT_CYCLES);

   localparam logic [CW-1:0] RST_LAST    = CW'(LDR_RST_CYCLES - 1);
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
   // The idle counter is one behind "cycles since last strobe", so the transition
   // fires on the edge where it would reach TIMEOUT_CYCLES-1.
   localparam logic [IW-1:0] IDLE_LAST   = IW'(TIMEOUT_CYCLES - 2);

   state_e                state_q, state_d;
   logic [CW-1:0]         cyc_cnt_q, cyc_cnt_d;
   logic [IW-1:0]         idle_cnt_q, idle_cnt_d;
   logic                  armed_q, armed_d;
   logic [ADDR_WIDTH-1:0] inst_count_q, inst_count_d;
   logic                  ldr_rst_n_q, ldr_rst_n_d;
   logic                  cpu_rst_n_q, cpu_rst_n_d;
   logic                  timeout_err_q, timeout_err_d;
   logic                  timeout_hit;

   assign timeout_hit = armed_q && !byte_strobe && (idle_cnt_q == IDLE_LAST);

   always_comb begin : next_state
      state_d = state_q;
      case (state_q)
         LDR_RESET: if (cyc_cnt_q == RST_LAST) state_d = LOAD;
         LOAD: begin
            if (ldr_prog_rdy)     state_d = SETTLE;
            else if (timeout_hit) state_d = ERROR;
         end
         SETTLE:    if (cyc_cnt_q == SETTLE_LAST) state_d = RUN;
         RUN,
         ERROR:     state_d = state_q;
         default:   state_d = LDR_RESET;
      endcase
      if (reload_req) state_d = LDR_RESET;
   end

   always_comb begin : counters
      cyc_cnt_d    = cyc_cnt_q;
      idle_cnt_d   = idle_cnt_q;
      armed_d      = armed_q;
      inst_count_d = inst_count_q;

      // A reload while already in LDR_RESET must also restart the count.
      if (state_d != state_q || reload_req)
         cyc_cnt_d = '0;
      else if (state_q == LDR_RESET || state_q == SETTLE)
         cyc_cnt_d = cyc_cnt_q + 1'b1;

      if (state_q == LOAD) begin
         if (ldr_inst_rdy) inst_count_d = inst_count_q + 1'b1;
         if (byte_strobe) begin
            armed_d    = 1'b1;
            idle_cnt_d = '0;
         end else if (armed_q) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
         end
      end

      if (state_d == LDR_RESET) begin
         inst_count_d = '0;
         armed_d      = 1'b0;
         idle_cnt_d   = '0;
      end
   end

   always_comb begin : reset_outputs
      ldr_rst_n_d   = (state_d == LOAD) || (state_d == SETTLE) || (state_d == RUN);
      cpu_rst_n_d   = (state_d == RUN);
      timeout_err_d = (state_d == ERROR);
   end

   always_comb begin : mem_mux
      mem_we    = 1'b0;
      mem_addr  = cpu_fetch_addr;
      mem_wdata = '0;
      if (state_q == LOAD) begin
         mem_we    = ldr_inst_rdy;
         mem_addr  = ldr_wr_addr;
         mem_wdata = ldr_wr_data;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q       <= LDR_RESET;
         cyc_cnt_q     <= '0;
         idle_cnt_q    <= '0;
         armed_q       <= 1'b0;
         inst_count_q  <= '0;
         ldr_rst_n_q   <= 1'b0;
         cpu_rst_n_q   <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cyc_cnt_q     <= cyc_cnt_d;
         idle_cnt_q    <= idle_cnt_d;
         armed_q       <= armed_d;
         inst_count_q  <= inst_count_d;
         ldr_rst_n_q   <= ldr_rst_n_d;
         cpu_rst_n_q   <= cpu_rst_n_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign ldr_rst_n   = ldr_rst_n_q;
   assign cpu_rst_n   = cpu_rst_n_q;
   assign timeout_err = timeout_err_q;
   assign inst_count  = inst_count_q;
   assign boot_state  = state_q;

endmodule

// File: tb/tb_boot_load_sequencer.sv
// Bench for boot_load_sequencer: directed vector table, corner-case sequences and
// random traffic checked against a timestamp-based reference model.
module tb_boot_load_sequencer;

   localparam int AW = 10;
   localparam int DW = 32;
   localparam int LRC = 4;
   localparam int SC  = 2;
   localparam int TC  = 16;

   localparam int P_RST = 0, P_LOAD = 1, P_SETTLE = 2, P_RUN = 3, P_ERR = 4;

   logic          clk, arst_n;
   logic          reload_req, byte_strobe, ldr_inst_rdy, ldr_prog_rdy;
   logic [AW-1:0] ldr_wr_addr, cpu_fetch_addr;
   logic [DW-1:0] ldr_wr_data;
   logic          mem_we, ldr_rst_n, cpu_rst_n, timeout_err;
   logic [AW-1:0] mem_addr, inst_count;
   logic [DW-1:0] mem_wdata;
   logic [2:0]    boot_state;

   boot_load_sequencer #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LDR_RST_CYCLES(LRC),
      .SETTLE_CYCLES(SC), .TIMEOUT_CYCLES(TC)
   ) dut (
      .clk(clk), .arst_n(arst_n), .reload_req(reload_req), .byte_strobe(byte_strobe),
      .ldr_inst_rdy(ldr_inst_rdy), .ldr_wr_addr(ldr_wr_addr), .ldr_wr_data(ldr_wr_data),
      .ldr_prog_rdy(ldr_prog_rdy), .cpu_fetch_addr(cpu_fetch_addr), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .ldr_rst_n(ldr_rst_n),
      .cpu_rst_n(cpu_rst_n), .timeout_err(timeout_err), .inst_count(inst_count),
      .boot_state(boot_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: phase plus timestamps of phase entry and last UART byte.
   int m_phase, m_cyc, m_entered, m_last_strobe, m_count;

   task automatic model_reset();
      m_phase = P_RST; m_cyc = 0; m_entered = 0; m_last_strobe = -1; m_count = 0;
   endtask

   task automatic model_step(input bit rr, input bit bs, input bit ir, input bit pr);
      int nxt;
      nxt = m_phase;
      case (m_phase)
         P_RST:    if (m_cyc - m_entered == LRC - 1) nxt = P_LOAD;
         P_LOAD: begin
            if (pr) nxt = P_SETTLE;
            else if (m_last_strobe >= 0 && !bs && (m_cyc - m_last_strobe == TC - 1)) nxt = P_ERR;
         end
         P_SETTLE: if (m_cyc - m_entered == SC - 1) nxt = P_RUN;
         default:  nxt = m_phase;
      endcase
      if (rr) nxt = P_RST;
      if (m_phase == P_LOAD && ir) m_count = (m_count + 1) % (1 << AW);
      if (m_phase == P_LOAD && bs) m_last_strobe = m_cyc;
      if (nxt != m_phase || rr) m_entered = m_cyc + 1;
      if (nxt == P_RST) begin
         m_count = 0;
         m_last_strobe = -1;
      end
      m_phase = nxt;
      m_cyc++;
   endtask

   // One clock: drive inputs, compare outputs against the model, advance both.
   task automatic cycle(input bit rr, input bit bs, input bit ir, input bit pr,
                        input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [AW-1:0] fa);
      reload_req = rr; byte_strobe = bs; ldr_inst_rdy = ir; ldr_prog_rdy = pr;
      ldr_wr_addr = wa; ldr_wr_data = wd; cpu_fetch_addr = fa;
      #1;
      chk("boot_state",  32'(boot_state),  32'(m_phase));
      chk("ldr_rst_n",   32'(ldr_rst_n),   32'(m_phase == P_LOAD || m_phase == P_SETTLE || m_phase == P_RUN));
      chk("cpu_rst_n",   32'(cpu_rst_n),   32'(m_phase == P_RUN));
      chk("timeout_err", 32'(timeout_err), 32'(m_phase == P_ERR));
      chk("inst_count",  32'(inst_count),  32'(m_count));
      chk("mem_we",      32'(mem_we),      32'(m_phase == P_LOAD && ir));
      if (m_phase == P_LOAD)
         chk("mem_addr_ld", 32'(mem_addr), 32'(wa));
      else if (m_phase == P_SETTLE || m_phase == P_RUN)
         chk("mem_addr_cpu", 32'(mem_addr), 32'(fa));
      if (m_phase == P_LOAD)     chk("mem_wdata_ld", mem_wdata, wd);
      else if (m_phase == P_RUN) chk("mem_wdata_run", mem_wdata, 32'h0);
      model_step(rr, bs, ir, pr);
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 10'h40);
   endtask

   task automatic do_reset();
      arst_n = 1'b0;
      reload_req = 1'b0; byte_strobe = 1'b0; ldr_inst_rdy = 1'b0; ldr_prog_rdy = 1'b0;
      ldr_wr_addr = '0; ldr_wr_data = '0; cpu_fetch_addr = '0;
      @(posedge clk); #1;
      arst_n = 1'b1;
      model_reset();
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_state"},  32'(boot_state),  32'd0);
      chk({tag, "_ldr_rst"}, 32'(ldr_rst_n),  32'd0);
      chk({tag, "_cpu_rst"}, 32'(cpu_rst_n),  32'd0);
      chk({tag, "_terr"},   32'(timeout_err), 32'd0);
      chk({tag, "_cnt"},    32'(inst_count),  32'd0);
      chk({tag, "_we"},     32'(mem_we),      32'd0);
   endtask

   // ctl = {reload, strobe, inst_rdy, prog_rdy}; flg = {ldr_rst_n, cpu_rst_n, timeout_err, mem_we}
   // chk = {check mem_addr, check mem_wdata}
   typedef struct {
      logic [3:0]    ctl;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      logic [AW-1:0] fa;
      logic [2:0]    st;
      logic [3:0]    flg;
      logic [AW-1:0] cnt;
      logic [1:0]    ck;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdat;
   } vec_t;

   vec_t tbl[13];
   int   k;

   initial begin
      tbl[0]  = '{4'b0000, 10'h0, 32'h0,        10'h0,  3'd0, 4'b0000, 10'd0, 2'b00, 10'h0,  32'h0};
      tbl[1]  = tbl[0];
      tbl[2]  = tbl[0];
      tbl[3]  = tbl[0];
      tbl[4]  = '{4'b0100, 10'h0, 32'h0,        10'h0,  3'd1, 4'b1000, 10'd0, 2'b11, 10'h0,  32'h0};
      tbl[5]  = '{4'b0110, 10'h0, 32'h00500093, 10'h0,  3'd1, 4'b1001, 10'd0, 2'b11, 10'h0,  32'h00500093};
      tbl[6]  = '{4'b0010, 10'h4, 32'h00A00113, 10'h0,  3'd1, 4'b1001, 10'd1, 2'b11, 10'h4,  32'h00A00113};
      tbl[7]  = '{4'b0001, 10'h0, 32'h0,        10'h10, 3'd1, 4'b1000, 10'd2, 2'b11, 10'h0,  32'h0};
      tbl[8]  = '{4'b0000, 10'h0, 32'h0,        10'h10, 3'd2, 4'b1000, 10'd2, 2'b10, 10'h10, 32'h0};
      tbl[9]  = '{4'b0010, 10'h8, 32'h12345678, 10'h14, 3'd2, 4'b1000, 10'd2, 2'b10, 10'h14, 32'h0};
      tbl[10] = '{4'b0010, 10'h8, 32'hDEADBEEF, 10'h18, 3'd3, 4'b1100, 10'd2, 2'b11, 10'h18, 32'h0};
      tbl[11] = '{4'b1010, 10'h8, 32'hDEADBEEF, 10'h1C, 3'd3, 4'b1100, 10'd2, 2'b11, 10'h1C, 32'h0};
      tbl[12] = '{4'b0000, 10'h0, 32'h0,        10'h20, 3'd0, 4'b0000, 10'd0, 2'b00, 10'h0,  32'h0};

      arst_n = 1'b0;
      reload_req = 1'b0; byte_strobe = 1'b0; ldr_inst_rdy = 1'b0; ldr_prog_rdy = 1'b0;
      ldr_wr_addr = '0; ldr_wr_data = '0; cpu_fetch_addr = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("por");
      arst_n = 1'b1;

      // Power-up, two-instruction load, settle, run, reload.
      for (int i = 0; i < 13; i++) begin
         {reload_req, byte_strobe, ldr_inst_rdy, ldr_prog_rdy} = tbl[i].ctl;
         ldr_wr_addr = tbl[i].wa; ldr_wr_data = tbl[i].wd; cpu_fetch_addr = tbl[i].fa;
         #1;
         chk($sformatf("v%0d_state", i), 32'(boot_state), 32'(tbl[i].st));
         chk($sformatf("v%0d_flags", i), 32'({ldr_rst_n, cpu_rst_n, timeout_err, mem_we}), 32'(tbl[i].flg));
         chk($sformatf("v%0d_cnt", i),   32'(inst_count), 32'(tbl[i].cnt));
         if (tbl[i].ck[1]) chk($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(tbl[i].addr));
         if (tbl[i].ck[0]) chk($sformatf("v%0d_wdata", i), mem_wdata, tbl[i].wdat);
         @(posedge clk); #1;
      end

      // Stalled stream: one byte then silence.
      do_reset();
      idle(LRC);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0);
      k = 0;
      while (boot_state != 3'd4 && k < 40) begin
         idle(1);
         k++;
      end
      chk("timeout_latency", 32'(k), 32'd15);
      chk("timeout_err_set", 32'(timeout_err), 32'd1);
      chk("err_ldr_rst_n",   32'(ldr_rst_n),   32'd0);
      idle(3);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      chk("err_reload_state", 32'(boot_state),  32'd0);
      chk("err_reload_terr",  32'(timeout_err), 32'd0);

      // prog_rdy on the exact timeout cycle wins.
      do_reset();
      idle(LRC);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0);
      idle(TC - 2);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, '0, '0, 10'h8);
      chk("race_state", 32'(boot_state),  32'd2);
      chk("race_terr",  32'(timeout_err), 32'd0);
      idle(4);

      // reload beats prog_rdy.
      do_reset();
      idle(LRC);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, '0, '0, '0);
      chk("reload_prio_state", 32'(boot_state), 32'd0);
      idle(6);

      // Asynchronous reset in the middle of a load.
      do_reset();
      idle(LRC);
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 10'h0, 32'h00500093, '0);
      chk("mid_cnt", 32'(inst_count), 32'd1);
      ldr_inst_rdy = 1'b1;
      #1 arst_n = 1'b0;
      #1 chk_reset_vals("mid");
      @(posedge clk); #1;
      arst_n = 1'b1;
      model_reset();
      idle(LRC);
      chk("restart_ldr_rst_n", 32'(ldr_rst_n),  32'd1);
      chk("restart_state",     32'(boot_state), 32'd1);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         cycle(bit'($urandom_range(0, 99) == 0),
               bit'($urandom_range(0, 19) == 0),
               bit'($urandom_range(0, 3) == 0),
               bit'($urandom_range(0, 39) == 0),
               AW'($urandom), DW'($urandom), AW'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
